// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared types, constants and helpers for the VLIW scoreboard
// Contents: FSEL_RF (select code for "read the register file"), RD_MAX_W
// (register-number width held in a tracker entry), trk_entry_t (one in-flight
// producer) and fwd_code() (stage/lane to forward-select code).
package vliw_pkg;

   localparam int unsigned FSEL_RF  = 0;
   localparam int          RD_MAX_W = 8;

   typedef struct packed {
      logic                valid;
      logic                load;
      logic [RD_MAX_W-1:0] rd;
   } trk_entry_t;

   // Stage is 1-based (1 = EX), lane is 0-based.
   function automatic int fwd_code(input int stage, input int lane, input int lanes);
      return 1 + (stage - 1) * lanes + lane;
   endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - priority search of one source register over the producer tracker
// Ports:
//   trk_i   in  DEPTH*LANES tracker entries, index (stage-1)*LANES + lane
//   reg_i   in  source register number
//   hit_o   out a valid producer of reg_i is in flight
//   stage_o out stage of the youngest producer (1 = EX)
//   lane_o  out lane of that producer
//   load_o  out that producer is a load
module sb_match
   import vliw_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 3,
   parameter int RW    = 3,
   parameter int STW   = $clog2(DEPTH + 1),
   parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  trk_entry_t     trk_i [DEPTH*LANES],
   input  logic [RW-1:0]  reg_i,
   output logic           hit_o,
   output logic [STW-1:0] stage_o,
   output logic [LW-1:0]  lane_o,
   output logic           load_o
);

   always_comb begin
      hit_o   = 1'b0;
      stage_o = '0;
      lane_o  = '0;
      load_o  = 1'b0;
      // Oldest stage first so younger matches overwrite; ascending lanes so
      // the highest lane of the winning stage is the one left standing.
      for (int s = DEPTH - 1; s >= 0; s--) begin
         for (int l = 0; l < LANES; l++) begin
            if (trk_i[s*LANES+l].valid && (trk_i[s*LANES+l].rd == RD_MAX_W'(reg_i))) begin
               hit_o   = 1'b1;
               stage_o = STW'(s + 1);
               lane_o  = LW'(l);
               load_o  = trk_i[s*LANES+l].load;
            end
         end
      end
   end

endmodule

// File: rtl/vliw_scoreboard.sv
// rtl/vliw_scoreboard.sv - hazard and forwarding controller for the multi-lane VLIW pipeline
// Config macro: SCOREBOARD_FWD_EN (defined: forward, stall on load-use only;
// undefined: no forwarding, stall on any in-flight RAW, fwd_sel tied to 0).
// Ports:
//   clk, reset (sync, active-low)
//   issue_valid/issue_we/issue_load/issue_rd  issuing bundle, per lane
//   src_valid/src_reg                         two sources per lane (lane l: 2l, 2l+1)
//   flush       kill the issuing bundle and the EX entry
//   stall       hold PC and IF/ID, bubble into EX
//   fwd_sel     per-source select, 0 = register file, else 1+(stage-1)*LANES+lane
//   waw_err     sticky intra-bundle same-rd write
//   stall_cnt   saturating stall-cycle count
module vliw_scoreboard
   import vliw_pkg::*;
#(
   parameter int LANES = 2,
   parameter int NREGS = 8,
   parameter int DEPTH = 3,
   localparam int RW  = $clog2(NREGS),
   localparam int SW  = $clog2(DEPTH*LANES + 1),
   localparam int STW = $clog2(DEPTH + 1),
   localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES-1:0]       issue_valid,
   input  logic [LANES-1:0]       issue_we,
   input  logic [LANES-1:0]       issue_load,
   input  logic [LANES*RW-1:0]    issue_rd,
   input  logic [2*LANES-1:0]     src_valid,
   input  logic [2*LANES*RW-1:0]  src_reg,
   input  logic                   flush,
   output logic                   stall,
   output logic [2*LANES*SW-1:0]  fwd_sel,
   output logic                   waw_err,
   output logic [15:0]            stall_cnt
);

   trk_entry_t trk_q [DEPTH*LANES];
   trk_entry_t trk_d [DEPTH*LANES];
   logic       waw_q, waw_d;
   logic [15:0] cnt_q, cnt_d;

   logic [2*LANES-1:0]          m_hit;
   logic [2*LANES-1:0][STW-1:0] m_stage;
   logic [2*LANES-1:0][LW-1:0]  m_lane;
   logic [2*LANES-1:0]          m_load;

   logic stall_raw;
   logic enter;
   logic waw_hit;

   for (genvar i = 0; i < 2*LANES; i++) begin : g_match
      sb_match #(
         .LANES (LANES),
         .DEPTH (DEPTH),
         .RW    (RW),
         .STW   (STW),
         .LW    (LW)
      ) u_match (
         .trk_i   (trk_q),
         .reg_i   (src_reg[i*RW +: RW]),
         .hit_o   (m_hit[i]),
         .stage_o (m_stage[i]),
         .lane_o  (m_lane[i]),
         .load_o  (m_load[i])
      );
   end

`ifdef SCOREBOARD_FWD_EN
   logic [2*LANES*SW-1:0] fwd_d;

   always_comb begin
      stall_raw = 1'b0;
      fwd_d     = {(2*LANES){SW'(FSEL_RF)}};
      for (int i = 0; i < 2*LANES; i++) begin
         if (src_valid[i] && m_hit[i]) begin
            // A load still in EX has no data yet: wait one cycle for MEM.
            if ((m_stage[i] == STW'(1)) && m_load[i]) begin
               if (issue_valid[i/2]) stall_raw = 1'b1;
            end else begin
               fwd_d[i*SW +: SW] = SW'(fwd_code(32'(m_stage[i]), 32'(m_lane[i]), LANES));
            end
         end
      end
   end

   assign fwd_sel = fwd_d;
`else
   logic unused_match;

   always_comb begin
      stall_raw = 1'b0;
      for (int i = 0; i < 2*LANES; i++) begin
         if (src_valid[i] && m_hit[i] && issue_valid[i/2]) stall_raw = 1'b1;
      end
   end

   assign fwd_sel      = '0;
   assign unused_match = ^{m_stage, m_lane, m_load};
`endif

   assign stall = stall_raw & ~flush;
   assign enter = ~flush & ~stall_raw;

   always_comb begin
      trk_d = trk_q;
      for (int s = DEPTH - 1; s >= 1; s--) begin
         for (int l = 0; l < LANES; l++) begin
            trk_d[s*LANES+l] = trk_q[(s-1)*LANES+l];
            if ((s == 1) && flush) trk_d[s*LANES+l].valid = 1'b0;
         end
      end
      for (int l = 0; l < LANES; l++) begin
         trk_d[l].valid = enter & issue_valid[l] & issue_we[l];
         trk_d[l].load  = issue_load[l];
         trk_d[l].rd    = RD_MAX_W'(issue_rd[l*RW +: RW]);
      end
   end

   always_comb begin
      waw_hit = 1'b0;
      for (int a = 0; a < LANES; a++) begin
         for (int b = a + 1; b < LANES; b++) begin
            if (issue_valid[a] && issue_we[a] && issue_valid[b] && issue_we[b] &&
                (issue_rd[a*RW +: RW] == issue_rd[b*RW +: RW])) waw_hit = 1'b1;
         end
      end
      waw_d = waw_q | (waw_hit & enter);
      cnt_d = (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH*LANES; i++) trk_q[i] <= '0;
         waw_q <= 1'b0;
         cnt_q <= 16'd0;
      end else begin
         trk_q <= trk_d;
         waw_q <= waw_d;
         cnt_q <= cnt_d;
      end
   end

   assign waw_err   = waw_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_vliw_scoreboard.sv
// tb/tb_vliw_scoreboard.sv - self-checking bench for vliw_scoreboard (LANES=2, NREGS=8, DEPTH=3)
module tb_vliw_scoreboard;

   logic        clk;
   logic        reset;
   logic [1:0]  issue_valid, issue_we, issue_load;
   logic [5:0]  issue_rd;
   logic [3:0]  src_valid;
   logic [11:0] src_reg;
   logic        flush;
   logic        stall;
   logic [11:0] fwd_sel;
   logic        waw_err;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   vliw_scoreboard #(.LANES(2), .NREGS(8), .DEPTH(3)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
      .issue_load(issue_load), .issue_rd(issue_rd), .src_valid(src_valid),
      .src_reg(src_reg), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
      .waw_err(waw_err), .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a list of in-flight producers, each with its age in
   // stages since issue (1 = EX ... 3 = WB).
   typedef struct {
      int rd;
      int lane;
      bit load;
      int age;
   } prod_t;

   prod_t inflight[$];
   bit    exp_stall;
   int    exp_fwd[4];
   bit    m_waw;
   int    m_cnt;

   function automatic void predict();
      bit raw;
      int best;
      raw = 0;
      for (int i = 0; i < 4; i++) begin
         exp_fwd[i] = 0;
         best = -1;
         if (src_valid[i]) begin
            for (int p = 0; p < inflight.size(); p++) begin
               if (inflight[p].rd == int'(src_reg[i*3 +: 3])) begin
                  if (best < 0 || inflight[p].age < inflight[best].age ||
                      (inflight[p].age == inflight[best].age && inflight[p].lane > inflight[best].lane))
                     best = p;
               end
            end
            if (best >= 0) begin
`ifdef SCOREBOARD_FWD_EN
               if (inflight[best].age == 1 && inflight[best].load) begin
                  if (issue_valid[i/2]) raw = 1;
               end else begin
                  exp_fwd[i] = 1 + (inflight[best].age - 1) * 2 + inflight[best].lane;
               end
`else
               if (issue_valid[i/2]) raw = 1;
`endif
            end
         end
      end
      exp_stall = raw && !flush;
   endfunction

   function automatic void model_commit();
      prod_t nq[$];
      prod_t e;
      bit    enter;
      if (!reset) begin
         inflight.delete();
         m_waw = 0;
         m_cnt = 0;
         return;
      end
      enter = !flush && !exp_stall;
      if (exp_stall && m_cnt < 65535) m_cnt++;
      if (enter && issue_valid == 2'b11 && issue_we == 2'b11 && issue_rd[2:0] == issue_rd[5:3])
         m_waw = 1;
      foreach (inflight[p]) begin
         e = inflight[p];
         if (!(flush && e.age == 1)) begin
            e.age++;
            if (e.age <= 3) nq.push_back(e);
         end
      end
      if (enter) begin
         for (int l = 0; l < 2; l++) begin
            if (issue_valid[l] && issue_we[l]) begin
               e.rd = int'(issue_rd[l*3 +: 3]);
               e.lane = l;
               e.load = issue_load[l];
               e.age = 1;
               nq.push_back(e);
            end
         end
      end
      inflight = nq;
   endfunction

   task automatic tick();
      predict();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = '0; issue_we = '0; issue_load = '0; issue_rd = '0;
      src_valid = '0; src_reg = '0; flush = 1'b0;
   endtask

   task automatic set_src(input int i, input int r);
      src_valid[i] = 1'b1;
      src_reg[i*3 +: 3] = 3'(r);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      issue_valid = 2'b01;
      set_src(0, 3);
      set_src(1, 5);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
      checks++; if (fwd_sel !== 12'd0) begin errors++; $display("FAIL reset_fwd: got %0h expected 0", fwd_sel); end
      checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw: got %0b expected 0", waw_err); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
      tick();
   endtask

   task automatic test_alu_forward();
      int es, ef;
`ifdef SCOREBOARD_FWD_EN
      es = 0; ef = 1;
`else
      es = 1; ef = 0;
`endif
      do_reset();
      issue_valid = 2'b01; issue_we = 2'b01; issue_rd[2:0] = 3'd3;
      tick();
      idle();
      issue_valid = 2'b10;
      set_src(2, 3);
      @(negedge clk);
      checks++; if (stall !== 1'(es)) begin errors++; $display("FAIL alu_stall: got %0b expected %0d", stall, es); end
      checks++; if (fwd_sel[8:6] !== 3'(ef)) begin errors++; $display("FAIL alu_fwd: got %0d expected %0d", fwd_sel[8:6], ef); end
      tick();
   endtask

   // Hold one bundle until the stall releases; checks stall length, final select and counter.
   task automatic hold_and_check(input string nm, input int src, input int exp_n, input int exp_f);
      int n;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (stall !== 1'b1) break;
         n++;
         tick();
      end
      checks++; if (n != exp_n) begin errors++; $display("FAIL %s_stall_cycles: got %0d expected %0d", nm, n, exp_n); end
      checks++; if (fwd_sel[src*3 +: 3] !== 3'(exp_f)) begin errors++; $display("FAIL %s_fwd: got %0d expected %0d", nm, fwd_sel[src*3 +: 3], exp_f); end
      checks++; if (stall_cnt !== 16'(exp_n)) begin errors++; $display("FAIL %s_cnt: got %0d expected %0d", nm, stall_cnt, exp_n); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      issue_valid = 2'b10; issue_we = 2'b10; issue_load = 2'b10; issue_rd[5:3] = 3'd5;
      tick();
      idle();
      issue_valid = 2'b01;
      set_src(0, 5);
`ifdef SCOREBOARD_FWD_EN
      hold_and_check("load_use", 0, 1, 4);
`else
      hold_and_check("load_use", 0, 3, 0);
`endif
   endtask

   task automatic test_raw_hold();
      do_reset();
      issue_valid = 2'b01; issue_we = 2'b01; issue_rd[2:0] = 3'd4;
      tick();
      idle();
      issue_valid = 2'b10;
      set_src(3, 4);
`ifdef SCOREBOARD_FWD_EN
      hold_and_check("raw", 3, 0, 1);
`else
      hold_and_check("raw", 3, 3, 0);
`endif
   endtask

   task automatic test_waw();
      do_reset();
      issue_valid = 2'b11; issue_we = 2'b11; issue_rd = {3'd2, 3'd2};
      tick();
      idle();
      issue_valid = 2'b01;
      set_src(0, 2);
      @(negedge clk);
      checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL waw_set: got %0b expected 1", waw_err); end
`ifdef SCOREBOARD_FWD_EN
      checks++; if (fwd_sel[2:0] !== 3'd2) begin errors++; $display("FAIL waw_fwd: got %0d expected 2", fwd_sel[2:0]); end
`else
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b expected 1", stall); end
`endif
      tick();
      idle();
      for (int k = 0; k < 4; k++) tick();
      @(negedge clk);
      checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL waw_sticky: got %0b expected 1", waw_err); end
      // A WAW bundle that is stalled never enters, so the flag must stay clear.
      do_reset();
      issue_valid = 2'b01; issue_we = 2'b01; issue_load = 2'b01; issue_rd[2:0] = 3'd6;
      tick();
      idle();
      issue_valid = 2'b11; issue_we = 2'b11; issue_rd = {3'd1, 3'd1};
      set_src(0, 6);
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_held_stall: got %0b expected 1", stall); end
      tick();
      idle();
      @(negedge clk);
      checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL waw_held: got %0b expected 0", waw_err); end
      tick();
   endtask

   task automatic test_flush_load_use();
      do_reset();
      issue_valid = 2'b10; issue_we = 2'b10; issue_load = 2'b10; issue_rd[5:3] = 3'd5;
      tick();
      idle();
      issue_valid = 2'b01;
      set_src(0, 5);
      flush = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b expected 0", stall); end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_next_stall: got %0b expected 0", stall); end
      checks++; if (fwd_sel[2:0] !== 3'd0) begin errors++; $display("FAIL flush_next_fwd: got %0d expected 0", fwd_sel[2:0]); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", stall_cnt); end
      tick();
   endtask

   task automatic test_reset_mid_flight();
      do_reset();
      issue_valid = 2'b11; issue_we = 2'b11; issue_load = 2'b11; issue_rd = {3'd1, 3'd1};
      tick();
      idle();
      issue_valid = 2'b11; issue_we = 2'b11; issue_rd = {3'd3, 3'd2};
      set_src(0, 1);
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall: got %0b expected 1", stall); end
      tick();
      @(negedge clk);
      checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL midrst_pre_waw: got %0b expected 1", waw_err); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL midrst_pre_cnt: got %0d expected 1", stall_cnt); end
      tick();
      idle();
      issue_valid = 2'b01; issue_we = 2'b01; issue_rd[2:0] = 3'd6;
      tick();
      do_reset();
      issue_valid = 2'b11;
      set_src(0, 1); set_src(1, 2); set_src(2, 3); set_src(3, 6);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %0b expected 0", stall); end
      checks++; if (fwd_sel !== 12'd0) begin errors++; $display("FAIL midrst_fwd: got %0h expected 0", fwd_sel); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", stall_cnt); end
      checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL midrst_waw: got %0b expected 0", waw_err); end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] iv;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         iv          = 2'($urandom_range(0, 3));
         reset       = ($urandom_range(0, 63) != 0);
         flush       = ($urandom_range(0, 7) == 0);
         issue_valid = iv;
         issue_we    = 2'($urandom_range(0, 3));
         issue_load  = 2'($urandom_range(0, 3));
         issue_rd    = 6'($urandom);
         src_valid   = 4'($urandom) & {iv[1], iv[1], iv[0], iv[0]};
         src_reg     = 12'($urandom);
         @(negedge clk);
         predict();
         checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %0b expected %0b", c, stall, exp_stall); end
         for (int i = 0; i < 4; i++) begin
            checks++; if (fwd_sel[i*3 +: 3] !== 3'(exp_fwd[i])) begin errors++; $display("FAIL rnd_fwd%0d c%0d: got %0d expected %0d", i, c, fwd_sel[i*3 +: 3], exp_fwd[i]); end
         end
         checks++; if (waw_err !== m_waw) begin errors++; $display("FAIL rnd_waw c%0d: got %0b expected %0b", c, waw_err, m_waw); end
         checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, stall_cnt, m_cnt); end
         tick();
      end
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      m_waw = 0;
      m_cnt = 0;
      exp_stall = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_alu_forward();
      test_load_use();
      test_raw_hold();
      test_waw();
      test_flush_load_use();
      test_reset_mid_flight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
